// File: rtl/gm_draw_pkg.sv
// Shared types and constants for the sprite draw responders.
package gm_draw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        FLUSH1,
        FLUSH2,
        DONE,
        RELEASE
    } draw_state_t;

    localparam int SCREEN_W     = 160;
    localparam int SCREEN_H     = 120;
    localparam int SPRITE_W_DEF = 16;
    localparam int SPRITE_H_DEF = 16;

    localparam logic [2:0] TRANSPARENT = 3'b000;

    // Keeps counter widths legal for degenerate 1-pixel dimensions.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/sprite_draw_responder_pixel_counter.sv
// Row-major sprite pixel walker: column/row position, linear ROM address
// and a flag marking the last pixel of the sprite.
module sprite_pixel_counter
    import gm_draw_pkg::*;
#(
    parameter int SPRITE_W = SPRITE_W_DEF,
    parameter int SPRITE_H = SPRITE_H_DEF,
    localparam int COL_W  = clog2_min1(SPRITE_W),
    localparam int ROW_W  = clog2_min1(SPRITE_H),
    localparam int ADDR_W = clog2_min1(SPRITE_W * SPRITE_H)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              adv,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic col_end;

    assign col_end = (col == COL_W'(SPRITE_W - 1));
    assign last    = col_end && (row == ROW_W'(SPRITE_H - 1));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (adv) begin
            addr <= last ? '0 : addr + 1'b1;
            if (col_end) begin
                col <= '0;
                row <= last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_draw_responder.sv
// Draws one sprite per enable_draw request and pulses draw_done.
// Define SPRITE_CLIP_EN to suppress pixels falling off the 160x120 screen.
module sprite_draw_responder
    import gm_draw_pkg::*;
#(
    parameter int SPRITE_W = SPRITE_W_DEF,
    parameter int SPRITE_H = SPRITE_H_DEF,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOR_W  = 3,
    parameter logic [COLOR_W-1:0] TRANSPARENT = gm_draw_pkg::TRANSPARENT,
    localparam int COL_W  = clog2_min1(SPRITE_W),
    localparam int ROW_W  = clog2_min1(SPRITE_H),
    localparam int ADDR_W = clog2_min1(SPRITE_W * SPRITE_H)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable_draw,
    input  logic [X_W-1:0]     obj_x,
    input  logic [Y_W-1:0]     obj_y,
    input  logic               clear_n,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic [X_W-1:0]     vga_x,
    output logic [Y_W-1:0]     vga_y,
    output logic [COLOR_W-1:0] vga_colour,
    output logic               vga_plot,
    output logic               draw_done,
    output logic [2:0]         obj_count
);

    draw_state_t      state;
    logic [X_W-1:0]   lx;
    logic [Y_W-1:0]   ly;
    logic [COL_W-1:0] col, p1_col;
    logic [ROW_W-1:0] row, p1_row;
    logic             last, scan, idle, p1_vld;
    logic [X_W-1:0]   px;
    logic [Y_W-1:0]   py;
    logic             on_screen;

    assign scan = (state == SCAN);
    assign idle = (state == IDLE);

    sprite_pixel_counter #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (idle),
        .adv   (scan),
        .col   (col),
        .row   (row),
        .addr  (rom_addr),
        .last  (last)
    );

`ifdef SPRITE_CLIP_EN
    logic [X_W:0] x_sum;
    logic [Y_W:0] y_sum;

    // One extra bit so an off-screen pixel is not hidden by wrap-around.
    assign x_sum     = {1'b0, lx} + (X_W+1)'(p1_col);
    assign y_sum     = {1'b0, ly} + (Y_W+1)'(p1_row);
    assign on_screen = (x_sum < (X_W+1)'(SCREEN_W)) && (y_sum < (Y_W+1)'(SCREEN_H));
    assign px        = x_sum[X_W-1:0];
    assign py        = y_sum[Y_W-1:0];
`else
    assign on_screen = 1'b1;
    assign px        = lx + X_W'(p1_col);
    assign py        = ly + Y_W'(p1_row);
`endif

    // Stage 1 holds the position while the ROM answers; stage 2 is the plot.
    always_ff @(posedge clk) begin
        if (reset) begin
            p1_vld     <= 1'b0;
            p1_col     <= '0;
            p1_row     <= '0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            p1_vld     <= scan;
            p1_col     <= col;
            p1_row     <= row;
            vga_x      <= px;
            vga_y      <= py;
            vga_colour <= rom_data;
            vga_plot   <= p1_vld && (rom_data != TRANSPARENT) && on_screen;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            draw_done <= 1'b0;
            lx        <= '0;
            ly        <= '0;
        end else begin
            draw_done <= 1'b0;
            case (state)
                IDLE: if (enable_draw) begin
                    lx    <= obj_x;
                    ly    <= obj_y;
                    state <= SCAN;
                end
                SCAN:    if (last) state <= FLUSH1;
                FLUSH1:  state <= FLUSH2;
                FLUSH2: begin
                    state     <= DONE;
                    draw_done <= 1'b1;
                end
                DONE:    state <= RELEASE;
                // Wait for the FSM to drop its request so it cannot re-trigger.
                RELEASE: if (!enable_draw) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !clear_n)
            obj_count <= 3'd0;
        else if (state == DONE && obj_count != 3'd7)
            obj_count <= obj_count + 3'd1;
    end

endmodule

// File: tb/tb_sprite_draw_responder.sv
// Scoreboard bench: stimulus pushes expected plots/dones, a monitor pops them.
module tb_sprite_draw_responder;

    localparam int N = 256;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable_draw = 1'b0;
    logic       clear_n = 1'b1;
    logic [7:0] obj_x = '0;
    logic [6:0] obj_y = '0;
    logic [7:0] rom_addr;
    logic [2:0] rom_data;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       draw_done;
    logic [2:0] obj_count;

    sprite_draw_responder dut (
        .clk         (clk),
        .reset       (reset),
        .enable_draw (enable_draw),
        .obj_x       (obj_x),
        .obj_y       (obj_y),
        .clear_n     (clear_n),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .draw_done   (draw_done),
        .obj_count   (obj_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Sprite ROM model: 1-cycle registered read.
    int rom_mode = 0;
    function automatic logic [2:0] rom_fn(input logic [7:0] a, input int m);
        case (m)
            1:       return a[0] ? 3'b011 : 3'b000;
            2:       return 3'b101;
            default: return 3'b100;
        endcase
    endfunction
    always @(posedge clk) rom_data <= rom_fn(rom_addr, rom_mode);

    typedef struct {
        int         c;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] col;
    } plot_t;

    plot_t pq[$];
    int    dq[$];
    int    checks = 0;
    int    errors = 0;
    bit    done_tb = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every plot and every done must match the head of its queue.
    initial begin
        plot_t e;
        int    d;
        while (!done_tb) begin
            @(negedge clk);
            if (vga_plot) begin
                checks++;
                if (pq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_plot at cycle %0d (%0d,%0d) colour %0d",
                             cyc, vga_x, vga_y, vga_colour);
                end else begin
                    e = pq.pop_front();
                    if (cyc != e.c || vga_x !== e.x || vga_y !== e.y || vga_colour !== e.col) begin
                        errors++;
                        $display("FAIL plot got cyc %0d (%0d,%0d) c%0d expected cyc %0d (%0d,%0d) c%0d",
                                 cyc, vga_x, vga_y, vga_colour, e.c, e.x, e.y, e.col);
                    end
                end
            end
            if (draw_done) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done at cycle %0d", cyc);
                end else begin
                    d = dq.pop_front();
                    if (cyc != d) begin
                        errors++;
                        $display("FAIL done_cycle got %0d expected %0d", cyc, d);
                    end
                end
                if (vga_plot) begin
                    errors++;
                    $display("FAIL done_plot_overlap at cycle %0d", cyc);
                end
            end
        end
    end

    // Push the plots a pixel range [0, kmax] should produce, issued at c0+1.
    task automatic expect_plots(input logic [7:0] x, input logic [6:0] y, input int mode,
                                input int c0, input int kmax);
        logic [2:0] c;
        int col, row;
        for (int k = 0; k <= kmax; k++) begin
            c   = rom_fn(8'(k), mode);
            col = k % 16;
            row = k / 16;
            if (c == 3'b000) continue;
`ifdef SPRITE_CLIP_EN
            if (int'(x) + col >= 160 || int'(y) + row >= 120) continue;
`endif
            pq.push_back('{c0 + 3 + k, 8'(int'(x) + col), 7'(int'(y) + row), c});
        end
    endtask

    task automatic do_draw(input logic [7:0] x, input logic [6:0] y, input int mode,
                           input int hold, input bit clr_at_done, input int exp_count);
        int c0, waited;
        @(negedge clk);
        rom_mode    = mode;
        obj_x       = x;
        obj_y       = y;
        enable_draw = 1'b1;
        c0          = cyc;
        expect_plots(x, y, mode, c0, N - 1);
        dq.push_back(c0 + N + 3);
        // Coordinates must be latched; scramble them once the request is taken.
        @(negedge clk);
        obj_x  = x ^ 8'hff;
        obj_y  = y ^ 7'h7f;
        waited = 0;
        while (!draw_done && waited < N + 20) begin
            @(negedge clk);
            waited++;
        end
        if (!draw_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got none expected within %0d cycles", N + 20);
        end
        if (clr_at_done) begin
            clear_n = 1'b0;
            @(posedge clk);
            #1 clear_n = 1'b1;
        end
        repeat (hold) @(negedge clk);
        if (hold > 0) check("release_rom_addr_idle", int'(rom_addr), 0);
        enable_draw = 1'b0;
        repeat (2) @(negedge clk);
        check("obj_count", int'(obj_count), exp_count);
    endtask

    initial begin
        int c0, waited;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rom_addr", int'(rom_addr), 0);
        check("reset_vga_x", int'(vga_x), 0);
        check("reset_vga_y", int'(vga_y), 0);
        check("reset_vga_colour", int'(vga_colour), 0);
        check("reset_vga_plot", int'(vga_plot), 0);
        check("reset_draw_done", int'(draw_done), 0);
        check("reset_obj_count", int'(obj_count), 0);
        reset = 1'b0;

        // Solid sprite, then hold the request 5 cycles past done.
        do_draw(8'd10, 7'd20, 0, 5, 1'b0, 1);
        // Even pixels transparent.
        do_draw(8'd10, 7'd20, 1, 0, 1'b0, 2);
        // Draws 3..9: count saturates at 7.
        for (int i = 3; i <= 9; i++)
            do_draw(8'(i * 7), 7'(i * 3), 0, 0, 1'b0, (i > 7) ? 7 : i);
        // Clear coincident with done wins.
        do_draw(8'd40, 7'd50, 0, 0, 1'b1, 0);
        do_draw(8'd0, 7'd0, 1, 0, 1'b0, 1);

        // Abort at pixel 100: plots up to pixel 98 appear, no done.
        @(negedge clk);
        rom_mode    = 0;
        obj_x       = 8'd30;
        obj_y       = 7'd40;
        enable_draw = 1'b1;
        c0          = cyc;
        expect_plots(8'd30, 7'd40, 0, c0, 98);
        waited = 0;
        while (rom_addr !== 8'd100 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("abort_reached_pixel100", int'(rom_addr), 100);
        reset       = 1'b1;
        enable_draw = 1'b0;
        @(negedge clk);
        check("abort_rom_addr", int'(rom_addr), 0);
        check("abort_vga_plot", int'(vga_plot), 0);
        check("abort_vga_x", int'(vga_x), 0);
        check("abort_vga_colour", int'(vga_colour), 0);
        check("abort_draw_done", int'(draw_done), 0);
        check("abort_obj_count", int'(obj_count), 0);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        check("abort_idle_rom_addr", int'(rom_addr), 0);

        // Right-edge sprite: clipped or wrapped depending on build.
        do_draw(8'd150, 7'd20, 2, 0, 1'b0, 1);

        repeat (5) @(negedge clk);
        check("plot_queue_drained", pq.size(), 0);
        check("done_queue_drained", dq.size(), 0);
        done_tb = 1'b1;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_draw_responder.md
Name: sprite_draw_responder

Overview:
- Responder side of the view FSM's enable/done drawing handshake: accepts a level enable_draw request and draws one sprite (gold, stone or diamond) at a latched (x, y).
- Scans a 1-cycle-latency sprite ROM, drives the VGA adapter plot interface, and returns a one-cycle draw_done.
- Counts completed draws so the view FSM can compare obj_count against its max. Count is cleared by the FSM's active-low clear.
- One instance per object type sits between the view FSM and the VGA adapter.

Parameters:
- SPRITE_W, 16, sprite width in pixels.
- SPRITE_H, 16, sprite height in pixels.
- X_W, 8, VGA x coordinate width (160-pixel screen).
- Y_W, 7, VGA y coordinate width (120-line screen).
- COLOR_W, 3, colour width.
- TRANSPARENT, 3'b000, ROM colour that suppresses plotting.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable_draw  in  1  draw request, held high by the FSM until it sees draw_done.
- obj_x  in  X_W  sprite top-left x; sampled only when a request is accepted.
- obj_y  in  Y_W  sprite top-left y; sampled only when a request is accepted.
- clear_n  in  1  active-low synchronous clear of obj_count (the FSM's resetn_gold_stone_diamond).
- rom_addr  out  log2(SPRITE_W*SPRITE_H)  sprite ROM address, row-major.
- rom_data  in  COLOR_W  ROM colour, valid 1 cycle after rom_addr.
- vga_x  out  X_W  plot x.
- vga_y  out  Y_W  plot y.
- vga_colour  out  COLOR_W  plot colour.
- vga_plot  out  1  plot strobe.
- draw_done  out  1  one-cycle completion pulse.
- obj_count  out  3  completed draws, saturating at 7.

Behaviour:
- Reset: state IDLE; rom_addr, vga_x, vga_y, vga_colour, vga_plot, draw_done and obj_count all 0. Reset mid-operation aborts the scan immediately; no done is issued.
- States: IDLE, SCAN, FLUSH1, FLUSH2, DONE, RELEASE. Let N = SPRITE_W*SPRITE_H.
- IDLE: if enable_draw is high, latch obj_x/obj_y, zero the pixel counter, go to SCAN.
- SCAN: rom_addr = k for k = 0..N-1, one per cycle; the column counter wraps at SPRITE_W and increments the row. After k = N-1, go to FLUSH1. enable_draw is ignored here: a dropped request still completes.
- FLUSH1 -> FLUSH2 -> DONE: unconditional, lets the two-stage data path drain.
- DONE: draw_done = 1 for exactly this cycle. obj_count += 1, saturating at 7. Go to RELEASE.
- RELEASE: stay while enable_draw = 1; go to IDLE when it is 0. This prevents a re-trigger while the FSM is still leaving its draw state.
- Data path: pixel k is issued at cycle t. Its colour arrives at t+1. vga_x = lx + col and vga_y = ly + row are registered with the colour, so the outputs for pixel k are visible at t+2.
- Plot rule: vga_plot = 1 exactly when the pixel's colour != TRANSPARENT; otherwise vga_plot = 0 (other vga_* outputs don't-care).
- Coordinate adds are truncated to X_W/Y_W, i.e. wrap modulo 2^X_W and 2^Y_W.
- Latency: request accepted at edge E; last plot possible in the cycle after E+N+1; draw_done high in the cycle after E+N+2. draw_done never overlaps vga_plot.
- Count clear: clear_n = 0 zeroes obj_count; clear wins over a simultaneous DONE increment. clear_n does not affect the scan.

Optional Feature:
- Macro SPRITE_CLIP_EN.
- When defined: a pixel whose unwrapped x >= 160 or y >= 120 forces vga_plot = 0. The sums are computed one bit wider before the compare.
- When undefined: coordinates wrap as above and there is no clipping logic.

Decomposition:
- Package gm_draw_pkg holds:
  - the state enum;
  - SCREEN_W = 160 and SCREEN_H = 120;
  - the default SPRITE_W/SPRITE_H;
  - TRANSPARENT.
- One sub-module, sprite_pixel_counter: row/column counter with clear, advance and a last flag (k = N-1).

Test Plan:
- Reset, then enable_draw = 1 with obj_x = 10, obj_y = 20 and a ROM of all 3'b100 -> 256 plots, first at (10, 20), last at (25, 35). draw_done is one cycle, 259 cycles after acceptance. obj_count = 1.
- ROM colour 0 at even addresses -> exactly 128 plots; vga_plot is never high for an even pixel.
- Hold enable_draw high for 5 cycles after draw_done -> no second scan; obj_count stays 1. Drop it -> IDLE; the next request redraws.
- Perform 9 draws -> obj_count saturates at 7. Pulse clear_n = 0 in the same cycle as draw_done -> obj_count = 0.
- Assert reset at pixel 100 -> all outputs 0 next cycle, no draw_done, state IDLE.
- obj_x = 150: with SPRITE_CLIP_EN, columns 10..15 (x >= 160) are not plotted; without it, those pixels wrap to x = 160..165 mod 256 and are plotted.
